// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with stall/flush control and a small FSM.
// Optional perf counters are built only when FD_PERF_CNT_EN is defined.
module fd_pipe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_F,
  input  logic        flush_D,
  input  logic        fetch_vld,
  input  logic [31:0] instr_F,
  input  logic [31:0] pc_F,
  input  logic [31:0] pcplus4_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pcplus4_D,
  output logic        vld_D,
  output logic [1:0]  state_D,
  output logic [7:0]  stall_len,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_FULL  = 2'b01,
    S_HELD  = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [7:0]  len_q, len_d;
  logic        vld;

  assign vld = (state_q == S_FULL) || (state_q == S_HELD);

  // Next-state: rst > flush > illegal-state recovery > stall > load/bubble
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    len_d   = len_q;
    if (rst || flush_D || state_q == S_BAD) begin
      state_d = S_EMPTY;
      instr_d = NOP;
      pc_d    = '0;
      pcp4_d  = '0;
      len_d   = '0;
    end else if (!en_F) begin
      if (state_q != S_EMPTY) begin
        state_d = S_HELD;
        if (len_q != 8'hFF) len_d = len_q + 8'd1;
      end
    end else if (fetch_vld) begin
      state_d = S_FULL;
      instr_d = instr_F;
      pc_d    = pc_F;
      pcp4_d  = pcplus4_F;
      len_d   = '0;
    end else begin
      state_d = S_EMPTY;
      instr_d = NOP;
      pc_d    = '0;
      pcp4_d  = '0;
      len_d   = '0;
    end
  end

  // Pipeline register and FSM state
  always_ff @(posedge clk) begin
    state_q <= state_d;
    instr_q <= instr_d;
    pc_q    <= pc_d;
    pcp4_q  <= pcp4_d;
    len_q   <= len_d;
  end

  assign instr_D   = instr_q;
  assign pc_D      = pc_q;
  assign pcplus4_D = pcp4_q;
  assign vld_D     = vld;
  assign state_D   = state_q;
  assign stall_len = len_q;

`ifdef FD_PERF_CNT_EN
  logic [31:0] scnt_q, scnt_d;
  logic [31:0] fcnt_q, fcnt_d;

  // Count stalled-valid cycles and flushes that kill a valid instruction
  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (rst) begin
      scnt_d = '0;
      fcnt_d = '0;
    end else if (flush_D) begin
      if (vld) fcnt_d = fcnt_q + 32'd1;
    end else if (!en_F) begin
      if (vld) scnt_d = scnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    scnt_q <= scnt_d;
    fcnt_q <= fcnt_d;
  end

  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/fd_pipe_reg.md
FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 en_F  in  1  fetch/decode advance enable from hazard control; 0 = load-use stall (hold).
REQ-004 flush_D  in  1  decode flush from hazard control (taken branch/jump in E).
REQ-005 fetch_vld  in  1  instr_F/pc_F carry a real fetched instruction this cycle.
REQ-006 instr_F  in  32  fetched instruction.
REQ-007 pc_F  in  32  fetch PC.
REQ-008 pcplus4_F  in  32  fetch PC+4.
REQ-009 instr_D  out  32  registered instruction to decode.
REQ-010 pc_D  out  32  registered PC.
REQ-011 pcplus4_D  out  32  registered PC+4.
REQ-012 vld_D  out  1  decode slot holds a real instruction (0 = bubble).
REQ-013 state_D  out  2  FSM state: 00 EMPTY, 01 FULL, 10 HELD.
REQ-014 stall_len  out  8  consecutive stall cycles on the current held instruction, saturating.
REQ-015 stall_cnt  out  32  total stall cycles (FD_PERF_CNT_EN only).
REQ-016 flush_cnt  out  32  total flush events that killed a valid instruction (FD_PERF_CNT_EN only).

Function
REQ-017 Bubble encoding SHALL be instr_D=32'h00000013 (addi x0,x0,0), pc_D=0, pcplus4_D=0, vld_D=0.
REQ-018 Priority each cycle SHALL be rst > flush_D > ~en_F > load.
REQ-019 flush_D=1 SHALL load a bubble next cycle, go to EMPTY and clear stall_len, regardless of en_F or fetch_vld.
REQ-020 flush_D=0, en_F=0 SHALL keep instr_D/pc_D/pcplus4_D/vld_D unchanged.
REQ-021 Stall from FULL or HELD SHALL go to HELD and increment stall_len (saturating at 8'hFF); stall from EMPTY SHALL stay EMPTY with stall_len unchanged.
REQ-022 flush_D=0, en_F=1, fetch_vld=1 SHALL load instr_F/pc_F/pcplus4_F with vld_D=1, go to FULL and clear stall_len.
REQ-023 flush_D=0, en_F=1, fetch_vld=0 SHALL load a bubble, go to EMPTY and clear stall_len.
REQ-024 Latency F->D SHALL be exactly one cycle; no combinational path from any input to any output.
REQ-025 vld_D SHALL be 1 iff state_D is FULL or HELD.
REQ-026 Encoding 11 of state_D SHALL never occur; if reached, it SHALL go to EMPTY with a bubble on the next cycle.

Reset
REQ-027 rst=1 SHALL, on the next edge, set state_D=EMPTY, load a bubble and clear stall_len, stall_cnt and flush_cnt.
REQ-028 rst SHALL override concurrent flush_D, en_F and fetch_vld, including during a HELD stall.
REQ-029 The first cycle after rst deasserts SHALL follow REQ-018..REQ-023 normally.

Configuration
REQ-030 Macro FD_PERF_CNT_EN defined: stall_cnt SHALL increment on every cycle with en_F=0, flush_D=0 and vld_D=1, and flush_cnt SHALL increment on every cycle with flush_D=1 and vld_D=1; both SHALL wrap at 2^32.
REQ-031 FD_PERF_CNT_EN undefined: stall_cnt and flush_cnt SHALL be tied to 0 and no counter flops SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Reset: rst=1 for 2 cycles with en_F=1, fetch_vld=1, instr_F=32'h00500093 -> instr_D=32'h00000013, vld_D=0, state_D=00, stall_len=0.
REQ-033 Load: en_F=1, fetch_vld=1, pc_F=32'h80000000, instr_F=32'h00500093 -> next cycle pc_D=32'h80000000, instr_D=32'h00500093, vld_D=1, state_D=01.
REQ-034 Stall: from FULL, en_F=0 for 3 cycles -> outputs unchanged, state_D=10, stall_len=1,2,3, stall_cnt +3 (FD_PERF_CNT_EN); en_F=1 -> new load, stall_len=0.
REQ-035 Flush beats stall: FULL, en_F=0 and flush_D=1 together -> next cycle vld_D=0, instr_D=32'h00000013, state_D=00, flush_cnt +1.
REQ-036 Saturation: from FULL, en_F=0 for 300 cycles -> stall_len holds 8'hFF from cycle 255 on; vld_D stays 1.
REQ-037 Fetch gap: en_F=1, fetch_vld=0 -> bubble, state_D=00; en_F=0 while EMPTY -> stays EMPTY, stall_len=0, stall_cnt unchanged.
